// File: rtl/rf_writeback.sv
// Write-back merge: ALU results (priority) and queued load responses onto the RF write port, registered (1 cycle).
// Loads are back-pressured by ld_rsp_ready when the queue is full; optional RF_WB_FWD_EN adds an in-flight bypass.
module rf_writeback #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_rsp_valid,
  output logic            ld_rsp_ready,
  input  logic [4:0]      ld_rsp_rd,
  input  logic [XLEN-1:0] ld_rsp_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef RF_WB_FWD_EN
  output logic            rs1_fwd_hit,
  output logic            rs2_fwd_hit,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(LDQ_DEPTH);

  logic [4:0]      q_rd   [LDQ_DEPTH];
  logic [XLEN-1:0] q_data [LDQ_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW:0]     count;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic            alu_sel;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Ready looks only at the registered count: a same-cycle pop does not free a slot.
  assign ld_rsp_ready = (count < DEPTH_C);
  assign push         = ld_rsp_valid && ld_rsp_ready;
  assign alu_sel      = alu_valid && (alu_rd != 5'd0);
  assign pop          = !alu_sel && (count != '0);
  assign head_rd      = q_rd[rptr];
  assign head_data    = q_data[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr]   <= ld_rsp_rd;
      q_data[wptr] <= ld_rsp_data;
    end
  end

  // Issue of a new load to the same rd overrides the clear from popping an older one.
  always_comb begin
    pending_nxt = pending;
    if (pop && (head_rd != 5'd0))
      pending_nxt[head_rd] = 1'b0;
    if (ld_issue_valid && (ld_issue_rd != 5'd0))
      pending_nxt[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pending  <= '0;
      rd_addr  <= 5'd0;
      rd_wdata <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (!push && pop)
        count <= count - (PW+1)'(1);
      pending <= pending_nxt;
      if (alu_sel) begin
        rd_addr  <= alu_rd;
        rd_wdata <= alu_data;
      end else if (pop) begin
        rd_addr  <= head_rd;
        rd_wdata <= head_data;
      end else begin
        rd_addr  <= 5'd0;
      end
    end
  end

`ifdef RF_WB_FWD_EN
  assign rs1_busy     = (rs1_addr != 5'd0) && pending[rs1_addr];
  assign rs2_busy     = (rs2_addr != 5'd0) && pending[rs2_addr];
  assign rs1_fwd_hit  = (rs1_addr != 5'd0) && (rd_addr == rs1_addr);
  assign rs2_fwd_hit  = (rs2_addr != 5'd0) && (rd_addr == rs2_addr);
  assign rs1_fwd_data = rd_wdata;
  assign rs2_fwd_data = rd_wdata;
`else
  // Without a bypass the register being written this cycle is not readable until next cycle.
  assign rs1_busy = (rs1_addr != 5'd0) && (pending[rs1_addr] || (rd_addr == rs1_addr));
  assign rs2_busy = (rs2_addr != 5'd0) && (pending[rs2_addr] || (rd_addr == rs2_addr));
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: expected writes queued per source at stimulus time, matched as rd_addr shows them.
module tb_rf_writeback;
  localparam int XLEN      = 32;
  localparam int LDQ_DEPTH = 2;
`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic            ld_rsp_valid;
  logic            ld_rsp_ready;
  logic [4:0]      ld_rsp_rd;
  logic [XLEN-1:0] ld_rsp_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
`ifdef RF_WB_FWD_EN
  logic            rs1_fwd_hit;
  logic            rs2_fwd_hit;
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;
`endif
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t alu_q[$];
  wr_t ld_q[$];
  int  outstanding [32];
  int  checks = 0;
  int  errors = 0;

  rf_writeback #(.XLEN(XLEN), .LDQ_DEPTH(LDQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
    .ld_rsp_rd(ld_rsp_rd), .ld_rsp_data(ld_rsp_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef RF_WB_FWD_EN
    .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .rd_addr(rd_addr), .rd_wdata(rd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write shown on rd_addr must be the next expected ALU or load write; also
  // flags stimulus that sends an ALU result to a register with a load outstanding.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_addr != 5'd0) begin
        checks++;
        if (alu_q.size() > 0 && alu_q[0].rd == rd_addr && alu_q[0].data == rd_wdata)
          void'(alu_q.pop_front());
        else if (ld_q.size() > 0 && ld_q[0].rd == rd_addr && ld_q[0].data == rd_wdata) begin
          outstanding[rd_addr]--;
          void'(ld_q.pop_front());
        end else begin
          errors++;
          $display("FAIL wr_order: got rd_addr=%0d rd_wdata=%h, expected alu head %0d/%h (n=%0d) or load head %0d/%h (n=%0d)",
                   rd_addr, rd_wdata,
                   (alu_q.size() > 0) ? alu_q[0].rd : 5'd0, (alu_q.size() > 0) ? alu_q[0].data : 32'd0, alu_q.size(),
                   (ld_q.size() > 0) ? ld_q[0].rd : 5'd0, (ld_q.size() > 0) ? ld_q[0].data : 32'd0, ld_q.size());
        end
      end
      if (alu_valid && alu_rd != 5'd0) begin
        checks++;
        if (outstanding[alu_rd] != 0) begin
          errors++;
          $display("FAIL alu_to_pending: alu_rd=%0d has %0d loads outstanding, required 0", alu_rd, outstanding[alu_rd]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid      = 1'b0;
    ld_issue_valid = 1'b0;
    ld_rsp_valid   = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
    if (rd != 5'd0) alu_q.push_back('{rd: rd, data: data});
  endtask

  task automatic issue(input logic [4:0] rd, input logic [XLEN-1:0] data);
    ld_issue_valid = 1'b1;
    ld_issue_rd    = rd;
    ld_q.push_back('{rd: rd, data: data});
    outstanding[rd]++;
  endtask

  task automatic rsp(input logic [4:0] rd, input logic [XLEN-1:0] data);
    ld_rsp_valid = 1'b1;
    ld_rsp_rd    = rd;
    ld_rsp_data  = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    alu_rd = 5'd0; alu_data = '0; ld_issue_rd = 5'd0; ld_rsp_rd = 5'd0; ld_rsp_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    foreach (outstanding[i]) outstanding[i] = 0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (rd_wdata !== '0) begin errors++; $display("FAIL reset_rd_wdata: got %h want 0", rd_wdata); end
    checks++; if (ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ld_rsp_ready); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", rs1_busy, rs2_busy); end
`ifdef RF_WB_FWD_EN
    checks++; if (rs1_fwd_hit !== 1'b0 || rs2_fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b%b want 00", rs1_fwd_hit, rs2_fwd_hit); end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_alu();
    alu(5'd5, 32'h1234);
    nxt();
    idle();
    @(negedge clk);
    checks++; if (rd_addr !== 5'd5 || rd_wdata !== 32'h1234) begin errors++; $display("FAIL alu_write: got %0d/%h want 5/00001234", rd_addr, rd_wdata); end
    nxt();
    @(negedge clk);
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL alu_idle_addr: got %0d want 0", rd_addr); end
    checks++; if (rd_wdata !== 32'h1234) begin errors++; $display("FAIL alu_idle_hold: got %h want 00001234", rd_wdata); end
    nxt();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) alu(5'(i + 1), 32'hA5A50000 | 32'(i));
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rd_addr !== 5'(i) || rd_wdata !== (32'hA5A50000 | 32'(i - 1))) begin
          errors++;
          $display("FAIL b2b_write%0d: got %0d/%h want %0d/%h", i, rd_addr, rd_wdata, i, 32'hA5A50000 | 32'(i - 1));
        end
      end
      nxt();
    end
    idle();
  endtask

  task automatic test_load_stall();
    logic exp_busy;
    rs1_addr = 5'd7;
    idle();
    issue(5'd7, 32'hCAFE);
    nxt();
    for (int c = 1; c <= 6; c++) begin
      idle();
      if (c == 1) rsp(5'd7, 32'hCAFE);
      if (c <= 3) alu(5'(c + 2), 32'h300 + 32'(c));
      @(negedge clk);
      if (c == 1) begin
        checks++; if (ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: got %b want 1", ld_rsp_ready); end
      end
      exp_busy = (c <= 4) ? 1'b1 : (c == 5) ? (FWD ? 1'b0 : 1'b1) : 1'b0;
      checks++; if (rs1_busy !== exp_busy) begin errors++; $display("FAIL stall_busy_c%0d: got %b want %b", c, rs1_busy, exp_busy); end
      if (c == 5) begin
        checks++; if (rd_addr !== 5'd7 || rd_wdata !== 32'hCAFE) begin errors++; $display("FAIL stall_write: got %0d/%h want 7/0000cafe", rd_addr, rd_wdata); end
`ifdef RF_WB_FWD_EN
        checks++; if (rs1_fwd_hit !== 1'b1 || rs1_fwd_data !== 32'hCAFE) begin errors++; $display("FAIL stall_fwd: got %b/%h want 1/0000cafe", rs1_fwd_hit, rs1_fwd_data); end
`endif
      end
      nxt();
    end
  endtask

  task automatic test_backpressure();
    bit exp_rdy [8];
    int k;
    bit acc;
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 3; j++) begin
      idle();
      issue(5'(11 + j), 32'hB000 + 32'(j));
      nxt();
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 4) alu(5'(20 + i), 32'hA000 + 32'(i));
      if (k < 3) rsp(5'(11 + k), 32'hB000 + 32'(k));
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (ld_rsp_ready !== exp_rdy[i]) begin errors++; $display("FAIL bp_ready%0d: got %b want %b", i, ld_rsp_ready, exp_rdy[i]); end
      end
      if (i == 5) begin
        checks++; if (rd_addr !== 5'd11) begin errors++; $display("FAIL bp_first_pop: got %0d want 11", rd_addr); end
      end
      acc = ld_rsp_valid && ld_rsp_ready;
      nxt();
      if (acc) k++;
    end
    checks++; if (k != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", k); end
    idle();
  endtask

  task automatic test_reissue();
    logic exp_busy;
    rs1_addr = 5'd9;
    for (int e = 0; e <= 8; e++) begin
      idle();
      if (e == 0) issue(5'd9, 32'h9001);
      if (e == 1) rsp(5'd9, 32'h9001);
      if (e == 2) issue(5'd9, 32'h9002);
      if (e == 5) rsp(5'd9, 32'h9002);
      @(negedge clk);
      if (e >= 3) begin
        exp_busy = (e == 7) ? (FWD ? 1'b0 : 1'b1) : (e == 8) ? 1'b0 : 1'b1;
        checks++; if (rs1_busy !== exp_busy) begin errors++; $display("FAIL reissue_busy_e%0d: got %b want %b", e, rs1_busy, exp_busy); end
      end
      if (e == 3) begin
        checks++; if (rd_addr !== 5'd9 || rd_wdata !== 32'h9001) begin errors++; $display("FAIL reissue_first: got %0d/%h want 9/00009001", rd_addr, rd_wdata); end
      end
      if (e == 7) begin
        checks++; if (rd_addr !== 5'd9 || rd_wdata !== 32'h9002) begin errors++; $display("FAIL reissue_second: got %0d/%h want 9/00009002", rd_addr, rd_wdata); end
      end
      nxt();
    end
  endtask

  task automatic test_zero();
    rs1_addr = 5'd0;
    rs2_addr = 5'd3;
    idle();
    alu(5'd0, 32'hDEAD);
    rsp(5'd0, 32'hBEEF);
    nxt();
    idle();
    alu(5'd0, 32'hDEAD);
    @(negedge clk);
    checks++; if (rd_addr !== 5'd0 || rd_wdata !== 32'h9002) begin errors++; $display("FAIL zero_alu: got %0d/%h want 0/00009002", rd_addr, rd_wdata); end
    nxt();
    idle();
    for (int f = 2; f <= 3; f++) begin
      @(negedge clk);
      checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL zero_rd_f%0d: got %0d want 0", f, rd_addr); end
      checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL zero_busy_f%0d: got %b%b want 00", f, rs1_busy, rs2_busy); end
      nxt();
    end
  endtask

  task automatic test_reset_mid();
    idle(); issue(5'd14, 32'h1414); nxt();
    idle(); issue(5'd15, 32'h1515); nxt();
    idle(); rsp(5'd14, 32'h1414); alu(5'd1, 32'h0101); nxt();
    idle(); rsp(5'd15, 32'h1515); alu(5'd2, 32'h0202);
    @(negedge clk);
    checks++; if (ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_one: got %b want 1", ld_rsp_ready); end
    nxt();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0303;
    rs1_addr = 5'd14; rs2_addr = 5'd15;
    @(negedge clk);
    checks++; if (ld_rsp_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_full: got %b want 0", ld_rsp_ready); end
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b%b want 11", rs1_busy, rs2_busy); end
    #2 reset = 1'b1;
    idle();
    #1;
    checks++; if (rd_addr !== 5'd0 || rd_wdata !== '0) begin errors++; $display("FAIL rm_async_rd: got %0d/%h want 0/0", rd_addr, rd_wdata); end
    checks++; if (ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL rm_async_ready: got %b want 1", ld_rsp_ready); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL rm_async_busy: got %b%b want 00", rs1_busy, rs2_busy); end
    ld_q.delete();
    foreach (outstanding[i]) outstanding[i] = 0;
    nxt();
    nxt();
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      checks++; if (rd_addr !== 5'd0 || ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL rm_after_g%0d: got rd_addr=%0d ready=%b want 0/1", g, rd_addr, ld_rsp_ready); end
      nxt();
    end
  endtask

  task automatic test_end();
    idle();
    repeat (3) nxt();
    checks++; if (alu_q.size() != 0) begin errors++; $display("FAIL end_alu_q: got %0d pending writes want 0", alu_q.size()); end
    checks++; if (ld_q.size() != 0) begin errors++; $display("FAIL end_ld_q: got %0d pending writes want 0", ld_q.size()); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_stall();
    test_backpressure();
    test_reissue();
    test_zero();
    test_reset_mid();
    test_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back stage for the integer register file. Merges single-cycle ALU results and out-of-order load responses onto the register file's single write port (`rd_addr`/`rd_wdata`). Holds a load-response queue and a per-register pending scoreboard so decode can stall reads of registers with outstanding writes. Sits between execute/LSU and the register file.

## Interface
- `XLEN`, 32, data width.
- `LDQ_DEPTH`, 2, load-response queue entries; power of two, ≥2.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `ld_issue_valid`  in  1  load issued this cycle; marks `ld_issue_rd` pending.
- `ld_issue_rd`  in  5  load destination register.
- `ld_rsp_valid`  in  1  load response offered.
- `ld_rsp_ready`  out  1  queue can accept a response.
- `ld_rsp_rd`  in  5  response destination register.
- `ld_rsp_data`  in  XLEN  response data.
- `rs1_addr`, `rs2_addr`  in  5  decode source registers to check.
- `rs1_busy`, `rs2_busy`  out  1  source not yet readable from register file; decode stalls.
- `rd_addr`  out  5  register-file write address; 0 = no write.
- `rd_wdata`  out  XLEN  register-file write data.
- `rs1_fwd_hit`, `rs2_fwd_hit`  out  1  (only with `RF_WB_FWD_EN`) forward valid.
- `rs1_fwd_data`, `rs2_fwd_data`  out  XLEN  (only with `RF_WB_FWD_EN`) forwarded value.

## Operation
- Register file writes the addressed register every cycle; idle must drive `rd_addr` = 0.
- Each cycle, select one write source: ALU if `alu_valid` and `alu_rd`≠0; else queue head if queue non-empty; else none. Selection registered into `rd_addr`/`rd_wdata`; no source → `rd_addr` ← 0, `rd_wdata` holds.
- `alu_valid` with `alu_rd`=0: no write; queue may drain that cycle.
- Queue: FIFO, `LDQ_DEPTH` entries, push on `ld_rsp_valid && ld_rsp_ready`, pop when selected. `ld_rsp_ready` = count < `LDQ_DEPTH` (registered count only, no same-cycle pop credit). Pointers wrap modulo `LDQ_DEPTH`. Push and pop same cycle: count unchanged.
- Responses with `ld_rsp_rd`=0 are pushed, popped as no-write (`rd_addr` 0), no scoreboard effect.
- Scoreboard: 31 pending bits (x1..x31). Set on `ld_issue_valid` with rd≠0; cleared at the edge the load entry for that rd is popped. Set and clear of same rd same cycle: set wins.
- Upstream guarantees no ALU result targets a pending register (issue stalls on busy); bench asserts it.
- `rsN_busy` = rsN≠0 and (pending[rsN] or (no `RF_WB_FWD_EN` and `rd_addr`==rsN)). Combinational from state and `rsN_addr`.

## Timing
- Reset: `rd_addr` 0, `rd_wdata` 0, queue empty, `ld_rsp_ready` 1, scoreboard clear, busy/fwd outputs 0. Reset mid-operation discards queued responses and pending bits immediately.
- ALU result at cycle N → `rd_addr`/`rd_wdata` valid cycle N+1 → register file updated edge end of N+1.
- Load response accepted at edge ending N → earliest pop cycle N+1 → `rd_addr` cycle N+2. Each ALU cycle delays queue drain by one.
- Pending bit clears in the cycle `rd_addr` first shows that load.

## Configuration
- `RF_WB_FWD_EN` defined: `rsN_fwd_hit` = rsN≠0 and `rd_addr`==rsN; `rsN_fwd_data` = `rd_wdata`; in-flight write no longer raises busy. Decode muxes fwd data over register-file data.
- Undefined: fwd ports absent; in-flight write keeps `rsN_busy` high one extra cycle.

## Test plan
- ALU x5=0x1234 cycle 3 → `rd_addr`=5, `rd_wdata`=0x1234 cycle 4 only; cycle 5 `rd_addr`=0.
- Issue load x7, response 0xCAFE while ALU valid 3 cycles → `rs1_busy`(x7)=1 throughout; x7 written cycle after ALU stops; busy drops same cycle (FWD_EN) / one cycle later (no FWD_EN).
- Three responses back-to-back with ALU continuously valid, depth 2 → `ld_rsp_ready` 0 after two accepts; third accepted after first pop; order preserved.
- Issue x9 and pop of earlier x9 load same cycle → x9 stays pending until second response written.
- ALU rd=0 and load rsp rd=0 → `rd_addr` stays 0, no scoreboard change; reset asserted with two queued → queue empty, busy 0, `rd_addr` 0 asynchronously.
